tx_core_gen: RTL and testbench
==============================

# tx_core_gen

Parametrised UART transmitter that succeeds the fixed 8N1/8-bit-parity transmit core. Adds a transmit FIFO, runtime-selectable character length (5–8 bits), parity on/off/even/odd, one or two stop bits, and a configurable oversampling ratio. It sits between the bus-side register file, which pushes bytes with `datStb`, and the serial pin. Bit timing comes from the shared baud-rate oversampling tick generator.

## Interface
Parameters:
- `OVERSAMPLE`, default 8: `brTickOs` pulses per bit period; legal range 2..64.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; power of two, range 2..64.

Ports:
- `clk`  in  1: single system clock; all logic rises on it.
- `arst`  in  1: asynchronous reset, active-low. Asserted at 0, released synchronously to `clk`.
- `brTickOs`  in  1: one-`clk` pulse at OVERSAMPLE × baud rate.
- `datStb`  in  1: one-`clk` push strobe for `dat`.
- `dat`  in  8: character to send, LSB first. Bits at or above `dataBits` are ignored.
- `dataBits`  in  2: character length; 0→5, 1→6, 2→7, 3→8 bits.
- `parityEn`  in  1: 1 inserts a parity bit after the data bits.
- `parityEven`  in  1: 1 selects even parity, 0 selects odd parity.
- `stopTwo`  in  1: 1 sends two stop bits, 0 sends one.
- `tx`  out  1: serial line; idle level is 1.
- `full`  out  1: FIFO holds FIFO_DEPTH entries.
- `empty`  out  1: FIFO holds no entries.
- `level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy`  out  1: a frame is in progress (state ≠ IDLE).
- `ovf`  out  1: one-`clk` pulse when a push is dropped.

## Operation
- Reset values: `tx`=1, `full`=0, `empty`=1, `level`=0, `busy`=0, `ovf`=0, state IDLE. FIFO pointers and the tick and bit counters are cleared.
- FIFO behaviour:
  - `datStb` with `full`=0 writes `dat` and increments `level`.
  - `datStb` with `full`=1 and no pop in the same cycle drops the word and pulses `ovf`.
  - Push and pop in the same cycle are both accepted and `level` is unchanged, including when the FIFO is full.
- Config latch: at each pop, `dataBits`, `parityEn`, `parityEven` and `stopTwo` are captured. Changing the inputs mid-frame has no effect on the frame in flight.
- Parity is computed over the `dataBits` LSBs only:
  - Even: the parity bit makes the total number of 1s (data plus parity) even.
  - Odd: the parity bit makes that total odd.
- State machine; every state lasts exactly OVERSAMPLE `brTickOs` pulses:
  - IDLE: `tx`=1. If `empty`=0, pop the FIFO head into the shift register, clear the tick counter, go to START.
  - START: `tx`=0; then go to DATA.
  - DATA: `tx`=shift[0], shifting right once per bit. After `dataBits`+5 bits, go to PARITY if parity is enabled, otherwise STOP1.
  - PARITY: `tx`=parity bit; then go to STOP1.
  - STOP1: `tx`=1; then go to STOP2 if `stopTwo`=1, otherwise IDLE.
  - STOP2: `tx`=1; then go to IDLE.
- Bit advance: tick counter 0..OVERSAMPLE-1. On a `brTickOs` pulse with counter=OVERSAMPLE-1, the counter wraps to 0 and the state or bit advances.
- Back-to-back frames: returning to IDLE with `empty`=0 pops in that same IDLE cycle, so there is no extra idle bit between frames.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously), the FIFO is flushed and the partial frame is abandoned.

## Timing
- `tx` is driven from a flop; no combinational path from any input to `tx`.
- Latency from push to start bit, with the FIFO empty and state IDLE:
  - `datStb` sampled at edge n writes the FIFO.
  - The pop occurs at edge n+1.
  - `tx` falls after edge n+1, i.e. 2 `clk` after the strobe.
- Start-bit duration: from pop to the OVERSAMPLE-th following `brTickOs` pulse. This is exactly one bit period, plus up to one tick of phase jitter.
- Frame length in bits: 1 (start) + (5..8) data + `parityEn` + (1 or 2) stop.
- `full`, `empty` and `level` are registered and update on the edge after a push or pop.
- `ovf` is asserted in the cycle after the dropped `datStb`.
- `busy` rises on the pop edge and falls on the edge entering IDLE.

## Test plan
- Push 0xA5 with dataBits=3, parity on, even, one stop bit, OVERSAMPLE=8 → `tx` sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). Each bit lasts 8 ticks; `busy` spans 11 bits.
- Push 0x1F with dataBits=0, parity on, odd, stopTwo=1 → 0, 1,1,1,1,1, parity 0, stop 1, stop 1 (9 bits). Bits 7:5 of `dat` never appear on `tx`.
- With FIFO_DEPTH=4, push 5 words in 5 consecutive cycles while a frame is in progress → `full`=1 after the 4th push, the 5th word is dropped with a single `ovf` pulse, and `level`=4.
- Queue 0x00, 0xFF, 0x55 in 8N1 → three frames back-to-back; the stop bit of one frame is immediately followed by the start bit of the next; `empty`=1 after the third pop.
- Assert `arst`=0 during the data bits → `tx`=1 within the same cycle, `level`=0, `busy`=0. After release with no pushes, `tx` stays 1.
- Push and pop in the same cycle while full → `level` stays 4, `ovf`=0, and the pushed word is transmitted last.

Source files
------------

// File: rtl/tx_core_gen.sv
// -----------------------------------------------------------------------------
// tx_core_gen -- UART transmitter with a transmit FIFO and runtime frame format
//
// Characters pushed with datStb are queued in a small FIFO and sent LSB first
// on tx. The frame format (5..8 data bits, optional even/odd parity, one or two
// stop bits) is taken from the config inputs at the moment a character leaves
// the FIFO, so config changes never disturb a frame already on the line.
// Bit timing comes from brTickOs; every frame bit lasts OVERSAMPLE ticks.
//
// Ports
//   clk        system clock, all flops rise on it
//   arst       asynchronous reset, active low (released synchronously)
//   brTickOs   one-clk pulse at OVERSAMPLE x baud rate
//   datStb     one-clk push strobe for dat
//   dat        character to send, LSB first
//   dataBits   character length: 0->5, 1->6, 2->7, 3->8 bits
//   parityEn   insert a parity bit after the data bits
//   parityEven 1 = even parity, 0 = odd parity
//   stopTwo    1 = two stop bits, 0 = one stop bit
//   tx         serial line, idles high, driven from a flop
//   full       FIFO holds FIFO_DEPTH entries
//   empty      FIFO holds no entries
//   level      FIFO occupancy
//   busy       a frame is in progress
//   ovf        one-clk pulse when a push had to be dropped
// -----------------------------------------------------------------------------
module tx_core_gen #(
   parameter int OVERSAMPLE = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic                          brTickOs,
   input  logic                          datStb,
   input  logic [7:0]                    dat,
   input  logic [1:0]                    dataBits,
   input  logic                          parityEn,
   input  logic                          parityEven,
   input  logic                          stopTwo,
   output logic                          tx,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(OVERSAMPLE);

   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } state_t;

   // Parity over the low (bits+5) data bits only; bits above the character
   // length are masked off before the reduction.
   function automatic logic parity_bit(input logic [7:0] data,
                                       input logic [1:0] bits,
                                       input logic       even);
      logic [7:0] mask;
      logic       odd_ones;
      mask     = 8'hFF >> (2'd3 - bits);
      odd_ones = ^(data & mask);
      return even ? odd_ones : ~odd_ones;
   endfunction

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ovf_q, ovf_d;
   logic          pop_s;
   logic          push_s;
   logic [7:0]    head_s;

   // ---------------------------------------------------------------- FSM
   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [1:0]    cfg_bits_q, cfg_bits_d;
   logic          cfg_par_en_q, cfg_par_en_d;
   logic          cfg_stop_two_q, cfg_stop_two_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          advance_s;

   // A pop happens in any IDLE cycle with data queued; when full, a push in the
   // same cycle is still accepted because the popped slot frees up at the edge.
   assign pop_s     = (state_q == ST_IDLE) && !empty_q;
   assign push_s    = datStb && (!full_q || pop_s);
   assign head_s    = mem_q[rd_ptr_q];
   assign advance_s = brTickOs && (tick_q == TICK_MAX);

   // FIFO pointer, occupancy and overflow next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == DEPTH_L);
      empty_d = (level_d == LW'(0));
      ovf_d   = datStb && full_q && !pop_s;
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= dat;
      end
   end

   // FIFO control registers
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         level_q  <= LW'(0);
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   // Frame sequencer next-state: state, tick/bit counters, shift register and
   // the config captured at pop time
   always_comb begin
      state_d        = state_q;
      bit_d          = bit_q;
      shift_d        = shift_q;
      par_d          = par_q;
      cfg_bits_d     = cfg_bits_q;
      cfg_par_en_d   = cfg_par_en_q;
      cfg_stop_two_d = cfg_stop_two_q;

      // Tick counter is held at zero in IDLE so the start bit measures a full
      // OVERSAMPLE ticks from the pop.
      if (state_q == ST_IDLE) begin
         tick_d = TW'(0);
      end else if (brTickOs) begin
         tick_d = advance_s ? TW'(0) : tick_q + TW'(1);
      end else begin
         tick_d = tick_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               state_d        = ST_START;
               shift_d        = head_s;
               bit_d          = 3'd0;
               par_d          = parity_bit(head_s, dataBits, parityEven);
               cfg_bits_d     = dataBits;
               cfg_par_en_d   = parityEn;
               cfg_stop_two_d = stopTwo;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (advance_s) begin
               state_d = ST_DATA;
               bit_d   = 3'd0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (advance_s) begin
               // Last data bit index is (dataBits + 4)
               if (bit_q == ({1'b0, cfg_bits_q} + 3'd4)) begin
                  state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (advance_s) begin
               state_d = ST_STOP1;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP1: begin
            if (advance_s) begin
               state_d = cfg_stop_two_q ? ST_STOP2 : ST_IDLE;
            end else begin
               state_d = ST_STOP1;
            end
         end
         ST_STOP2: begin
            if (advance_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP2;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Line level is decoded from the next state so tx is a plain flop
      case (state_d)
         ST_IDLE:   tx_d = 1'b1;
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         ST_STOP1:  tx_d = 1'b1;
         ST_STOP2:  tx_d = 1'b1;
         default:   tx_d = 1'b1;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Frame sequencer registers; tx returns high asynchronously on reset
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q        <= ST_IDLE;
         tick_q         <= TW'(0);
         bit_q          <= 3'd0;
         shift_q        <= 8'd0;
         par_q          <= 1'b0;
         cfg_bits_q     <= 2'd3;
         cfg_par_en_q   <= 1'b0;
         cfg_stop_two_q <= 1'b0;
         tx_q           <= 1'b1;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_q         <= tick_d;
         bit_q          <= bit_d;
         shift_q        <= shift_d;
         par_q          <= par_d;
         cfg_bits_q     <= cfg_bits_d;
         cfg_par_en_q   <= cfg_par_en_d;
         cfg_stop_two_q <= cfg_stop_two_d;
         tx_q           <= tx_d;
         busy_q         <= busy_d;
      end
   end

   assign tx    = tx_q;
   assign full  = full_q;
   assign empty = empty_q;
   assign level = level_q;
   assign busy  = busy_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_tx_core_gen.sv
// -----------------------------------------------------------------------------
// tb_tx_core_gen -- self-checking bench for tx_core_gen
//
// A frame-level model (queue of characters, frame built as a bit vector, ticks
// counted since the pop) predicts every registered output each cycle. A line
// recorder samples tx in the middle of each bit so whole frames can be held
// against hand-written bit patterns.
// -----------------------------------------------------------------------------
module tb_tx_core_gen;

   localparam int OS    = 8;
   localparam int DEPTH = 4;
   localparam int TP    = 3;   // clk cycles per brTickOs pulse

   logic       clk;
   logic       arst;
   logic       brTickOs;
   logic       datStb;
   logic [7:0] dat;
   logic [1:0] dataBits;
   logic       parityEn;
   logic       parityEven;
   logic       stopTwo;
   logic       tx;
   logic       full;
   logic       empty;
   logic [2:0] level;
   logic       busy;
   logic       ovf;

   int checks   = 0;
   int failures = 0;

   tx_core_gen #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .arst      (arst),
      .brTickOs  (brTickOs),
      .datStb    (datStb),
      .dat       (dat),
      .dataBits  (dataBits),
      .parityEn  (parityEn),
      .parityEven(parityEven),
      .stopTwo   (stopTwo),
      .tx        (tx),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .busy      (busy),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Frame as a bit vector, index 0 = start bit; unused high bits stay 1
   function automatic logic [11:0] frame_vec(input logic [7:0] d, input logic [1:0] db,
                                             input logic pe, input logic ev);
      logic [11:0] v;
      int          n;
      logic        ones;
      v    = 12'hFFF;
      v[0] = 1'b0;
      n    = int'(db) + 5;
      ones = 1'b0;
      for (int i = 0; i < n; i++) begin
         v[1 + i] = d[i];
         ones     = ones ^ d[i];
      end
      if (pe) v[1 + n] = ev ? ones : ~ones;
      return v;
   endfunction

   function automatic int frame_len(input logic [1:0] db, input logic pe, input logic s2);
      return 1 + int'(db) + 5 + int'(pe) + 1 + int'(s2);
   endfunction

   // ------------------------------------------------------------ model
   logic [7:0]  m_fifo[$];
   bit          m_active;
   int          m_ticks;
   int          m_len;
   logic [11:0] m_bits;
   logic        m_ovf;

   task automatic m_reset();
      m_fifo.delete();
      m_active = 1'b0;
      m_ticks  = 0;
      m_len    = 0;
      m_bits   = 12'hFFF;
      m_ovf    = 1'b0;
   endtask

   initial begin
      bit         old_active;
      int         old_size;
      bit         pop;
      logic [7:0] b;
      m_reset();
      forever begin
         @(posedge clk or negedge arst);
         if (!arst) begin
            m_reset();
         end else begin
            old_active = m_active;
            old_size   = m_fifo.size();
            pop        = 1'b0;
            m_ovf      = 1'b0;
            if (old_active && brTickOs) begin
               m_ticks++;
               if (m_ticks == m_len * OS) m_active = 1'b0;
            end
            if (!old_active && old_size > 0) begin
               pop      = 1'b1;
               b        = m_fifo.pop_front();
               m_bits   = frame_vec(b, dataBits, parityEn, parityEven);
               m_len    = frame_len(dataBits, parityEn, stopTwo);
               m_active = 1'b1;
               m_ticks  = 0;
            end
            if (datStb) begin
               if (old_size < DEPTH || pop) m_fifo.push_back(dat);
               else m_ovf = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------ tick source
   initial begin
      int tcnt;
      tcnt     = 0;
      brTickOs = 1'b0;
      forever begin
         @(negedge clk);
         tcnt     = (tcnt + 1) % TP;
         brTickOs = (tcnt == 0);
      end
   end

   // ------------------------------------------------------------ compare
   bit cmp_en = 1'b0;
   int ovf_cnt = 0;

   initial begin
      logic exp_tx;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            exp_tx = m_active ? m_bits[m_ticks / OS] : 1'b1;
            check("cyc_tx",    tx,    exp_tx);
            check("cyc_busy",  busy,  m_active);
            check("cyc_level", level, m_fifo.size());
            check("cyc_full",  full,  (m_fifo.size() == DEPTH));
            check("cyc_empty", empty, (m_fifo.size() == 0));
            check("cyc_ovf",   ovf,   m_ovf);
         end
         if (ovf === 1'b1) ovf_cnt++;
      end
   end

   // ------------------------------------------------------------ line recorder
   logic [15:0] cap;
   int          cap_n = 0;
   logic [15:0] last_frame = 16'h0;
   int          last_n = 0;
   int          frames_done = 0;

   initial begin
      logic lt;
      logic busy_prev;
      int   cnt;
      busy_prev = 1'b0;
      cnt       = 0;
      cap       = 16'h0;
      forever begin
         @(posedge clk);
         lt = brTickOs;
         @(negedge clk);
         if (busy === 1'b1 && busy_prev !== 1'b1) begin
            cnt   = 0;
            cap_n = 0;
            cap   = 16'h0;
         end else if (busy === 1'b1 && lt) begin
            cnt++;
            if ((cnt % OS) == (OS / 2) && cap_n < 16) begin
               cap[cap_n] = tx;
               cap_n++;
            end
         end
         if (busy !== 1'b1 && busy_prev === 1'b1) begin
            last_frame = cap;
            last_n     = cap_n;
            frames_done++;
         end
         busy_prev = busy;
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic push(input logic [7:0] d);
      dat    = d;
      datStb = 1'b1;
      @(negedge clk);
      datStb = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((busy !== 1'b0 || empty !== 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         failures++;
         $display("FAIL wait_idle_timeout actual=busy still high required=idle within %0d cycles", limit);
      end
      repeat (2) @(negedge clk);
   endtask

   logic [11:0] v;
   logic [7:0]  ovf_words [5] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
   int          base;
   int          n;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst       = 1'b0;
      datStb     = 1'b0;
      dat        = 8'h00;
      dataBits   = 2'd3;
      parityEn   = 1'b0;
      parityEven = 1'b0;
      stopTwo    = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_tx",    tx,    1'b1);
      check("rst_full",  full,  1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_level", level, 3'd0);
      check("rst_busy",  busy,  1'b0);
      check("rst_ovf",   ovf,   1'b0);
      arst   = 1'b1;
      cmp_en = 1'b1;

      // pin the model's frame builder
      v = frame_vec(8'hA5, 2'd3, 1'b1, 1'b1);
      check("model_vec_a5", v[10:0], 11'b10101001010);
      check("model_len_a5", frame_len(2'd3, 1'b1, 1'b0), 11);
      v = frame_vec(8'h1F, 2'd0, 1'b1, 1'b0);
      check("model_vec_1f", v[8:0], 9'b110111110);
      check("model_len_1f", frame_len(2'd0, 1'b1, 1'b1), 9);
      repeat (5) @(negedge clk);

      // 0xA5, 8 bits, even parity, one stop; also push-to-start latency
      dataBits = 2'd3; parityEn = 1'b1; parityEven = 1'b1; stopTwo = 1'b0;
      push(8'hA5);
      check("lat_level_after_push", level, 3'd1);
      check("lat_tx_before_pop",    tx,    1'b1);
      @(negedge clk);
      check("lat_tx_start",   tx,    1'b0);
      check("lat_busy",       busy,  1'b1);
      check("lat_empty",      empty, 1'b1);
      wait_idle(2000);
      check("a5_len",  last_n,           11);
      check("a5_bits", last_frame[10:0], 11'b10101001010);

      // 0x1F, 5 bits, odd parity, two stops; config changed mid-frame
      dataBits = 2'd0; parityEn = 1'b1; parityEven = 1'b0; stopTwo = 1'b1;
      push(8'h1F);
      @(negedge clk);
      dataBits = 2'd3; parityEn = 1'b0; parityEven = 1'b1; stopTwo = 1'b0;
      wait_idle(2000);
      check("1f_len",  last_n,          9);
      check("1f_bits", last_frame[8:0], 9'b110111110);

      // overflow: five pushes while a frame is in flight
      push(8'h11);
      @(negedge clk);
      base = ovf_cnt;
      for (int i = 0; i < 5; i++) begin
         dat    = ovf_words[i];
         datStb = 1'b1;
         @(negedge clk);
         if (i == 3) check("ovf_full_after_4th", full, 1'b1);
      end
      datStb = 1'b0;
      @(negedge clk);
      check("ovf_pulses", ovf_cnt - base, 1);
      check("ovf_level",  level,          3'd4);
      check("ovf_full",   full,           1'b1);

      // push in the pop cycle while full
      n = 0;
      while (m_active && n < 5000) begin
         @(negedge clk);
         n++;
      end
      dat    = 8'hC3;
      datStb = 1'b1;
      @(negedge clk);
      datStb = 1'b0;
      check("pp_level", level, 3'd4);
      check("pp_ovf",   ovf,   1'b0);
      check("pp_full",  full,  1'b1);
      wait_idle(20000);
      check("pp_last_len",  last_n,          10);
      check("pp_last_bits", last_frame[9:0], 10'b1110000110);

      // back-to-back 8N1 frames
      base = frames_done;
      push(8'h00);
      push(8'hFF);
      push(8'h55);
      wait_idle(5000);
      check("b2b_frames",    frames_done - base, 3);
      check("b2b_last_bits", last_frame[9:0],    10'b1010101010);

      // reset during the data bits
      push(8'h00);
      push(8'h00);
      repeat (4 * OS * TP) @(negedge clk);
      check("arst_pre_tx",    tx,    1'b0);
      check("arst_pre_level", level, 3'd1);
      @(posedge clk);
      #2;
      arst = 1'b0;
      #1;
      check("arst_tx",    tx,    1'b1);
      check("arst_level", level, 3'd0);
      check("arst_busy",  busy,  1'b0);
      check("arst_empty", empty, 1'b1);
      repeat (2) @(negedge clk);
      arst = 1'b1;
      repeat (200) @(negedge clk);
      check("post_arst_tx",   tx,   1'b1);
      check("post_arst_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
